pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Control FSM for the convolution PE datapath (`dp`). It loads the stride and filter-size registers on `start`. It then issues `put_data`/`put_filter` element pairs while both operands are available and closes each filter window with `store_buffer`/`clear_sum`. At row and filter boundaries it steps `next_filter`/`next_row`, and pulses `done` after the last configured row. It sits between the top-level testbench/host and `dp`, driving every controller input of `dp` and consuming its status outputs.

## Interface
Clock `clk`, reset `rst`; one clock; reset is asynchronous and active-high.

Parameters:
- `FILTER_SIZE_REG_SIZE`, default 8: width of `filter_size` and of the window element counter.
- `ROW_CNT_W`, default 8: width of `total_rows` and `row_idx`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: async active-high reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `filter_size` in FILTER_SIZE_REG_SIZE: elements per window; latched in CONFIG.
- `total_rows` in ROW_CNT_W: output rows to process; latched in CONFIG; 0 is treated as 1.
- `psum_ready` in 1: psum sink can accept a `store_buffer`.
- `av_data`, `av_filter`, `co_filter`, `end_of_row`, `end_of_filter` in 1 each: status from `dp`.
- `ld_stride`, `ld_fileSize`, `put_data`, `put_filter`, `clear_sum`, `store_buffer`, `next_filter`, `next_row` out 1 each: controls to `dp`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.
- `row_idx` out ROW_CNT_W: current row, 0-based.
- `err` out 1: sticky window-length mismatch; cleared only by `rst` or the next `start`.

## Operation
States: IDLE, CONFIG, WAIT, MAC, STORE, NXT_FILT, NXT_ROW, DONE.
- IDLE: all controls 0. `start` moves to CONFIG.
- CONFIG, one cycle:
  - asserts `ld_stride`, `ld_fileSize` and `clear_sum`;
  - latches `filter_size`/`total_rows` internally;
  - zeroes `row_idx`, the element counter and `err`;
  - moves to WAIT.
- WAIT: moves to MAC when `av_data && av_filter`.
- MAC:
  - `put_data = put_filter = av_data && av_filter`, a Mealy output. A missing operand is a stall: no issue, state held.
  - Each issue increments `elem_cnt`.
  - A window ends on the issue cycle where `co_filter` is high, or where `elem_cnt == filter_size-1`. On that cycle `elem_cnt` is cleared and the FSM goes to STORE.
  - If exactly one of those two conditions holds, `err` is set. The window still ends.
- STORE:
  - `store_buffer = clear_sum = psum_ready`; the state holds while `psum_ready` is 0.
  - On the accepting cycle, the next state is chosen from `end_of_row`/`end_of_filter` sampled that cycle:
    - `!end_of_row` goes to WAIT.
    - `end_of_row && !end_of_filter` goes to NXT_FILT.
    - `end_of_row && end_of_filter` goes to NXT_ROW.
- NXT_FILT: `next_filter = 1` for one cycle, then WAIT.
- NXT_ROW: `next_row = 1` for one cycle.
  - If `row_idx == max(total_rows,1)-1`, go to DONE.
  - Otherwise increment `row_idx` (wraps modulo 2^ROW_CNT_W) and go to WAIT.
- DONE: `done = 1` for one cycle, then IDLE. `row_idx` holds its final value until the next CONFIG.
- `filter_size == 0` is treated as 1, so every issue ends a window.

## Timing
- Reset state: IDLE, every output 0, `row_idx = 0`, `elem_cnt = 0`, `err = 0`. Reset mid-job aborts at once with no `done`.
- Output decode:
  - `put_*` are combinational from state and `av_*`.
  - `store_buffer`/`clear_sum` in STORE are combinational from `psum_ready`.
  - All other outputs are pure Moore outputs.
- Latency: `start` to first possible `put_data` is 2 cycles (CONFIG, WAIT). The last put of a window to `store_buffer` is 1 cycle when `psum_ready` is high. `next_row` to the following WAIT is 1 cycle.
- `start` in any state other than IDLE is ignored.
- `ld_*` and `next_*` never coincide with `put_*`.

## Structure
- Shared package `pe_seq_pkg`:
  - state enum `pe_seq_state_t`;
  - default widths `FILTER_SIZE_REG_SIZE` and `ROW_CNT_W`.
- One natural sub-module, `pe_window_counter`: the element counter plus the `co_filter` cross-check that produces `err`.
- Rows are counted with the existing `Counter` module.

## Test plan
- **Basic job:** `filter_size=3`, `total_rows=1`, `av_*` tied high, `co_filter` on the 3rd put, `end_of_row`/`end_of_filter` high at the first STORE. Expect `ld_*` at cycle 1, puts at cycles 3–5, `store_buffer` at 6, `next_row` at 7, `done` at 8, `busy` low at 9.
- **Operand stall:** drop `av_filter` for 2 cycles mid-window. Expect no puts during the drop, exactly 3 puts per window, and `elem_cnt` preserved.
- **Psum backpressure:** `psum_ready=0` for 4 cycles at STORE. Expect `store_buffer` and `clear_sum` only on the single accept cycle.
- **Boundaries:** `end_of_row` without `end_of_filter`, then both, with `total_rows=2`. Expect the sequence `next_filter`, `next_row`, `next_filter`, `next_row`, then `done`, with `row_idx` going 0, 1, 1.
- **Mismatch:** `co_filter` on the 2nd put with `filter_size=3`. Expect `err` set and held through `done`, and cleared by the next `start`.
- **Async reset:** assert `rst` in MAC. Expect all outputs 0 in the same cycle, no `done`, and a new `start` that runs cleanly.

Source files
------------

// File: rtl/pe_seq_pkg.sv
//------------------------------------------------------------------------------
// pe_seq_pkg : shared state encoding and default widths for pe_sequencer
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pe_seq_pkg;

  localparam int FILTER_SIZE_REG_SIZE = 8;
  localparam int ROW_CNT_W            = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONFIG   = 3'd1,
    WAIT     = 3'd2,
    MAC      = 3'd3,
    STORE    = 3'd4,
    NXT_FILT = 3'd5,
    NXT_ROW  = 3'd6,
    DONE     = 3'd7
  } pe_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/Counter.sv
//------------------------------------------------------------------------------
// Counter  : up counter with synchronous clear and count enable
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module Counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_window_counter.sv
//------------------------------------------------------------------------------
// pe_window_counter : per-window element counter with co_filter cross-check
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_window_counter #(
  parameter int FILTER_SIZE_REG_SIZE = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic                            issue,
  input  logic                            co_filter,
  output logic                            window_end,
  output logic                            err
);

  logic [FILTER_SIZE_REG_SIZE-1:0] size_q;
  logic [FILTER_SIZE_REG_SIZE-1:0] elem_cnt;
  logic [FILTER_SIZE_REG_SIZE-1:0] last_idx;
  logic                            at_last;

  // A zero size behaves as a one-element window.
  assign last_idx   = (size_q == '0) ? '0 : size_q - FILTER_SIZE_REG_SIZE'(1);
  assign at_last    = (elem_cnt == last_idx);
  assign window_end = issue && (co_filter || at_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= '0;
      elem_cnt <= '0;
      err      <= 1'b0;
    end else if (load) begin
      size_q   <= filter_size;
      elem_cnt <= '0;
      err      <= 1'b0;
    end else if (issue) begin
      elem_cnt <= window_end ? '0 : elem_cnt + FILTER_SIZE_REG_SIZE'(1);
      if (co_filter != at_last) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_sequencer.sv
//------------------------------------------------------------------------------
// pe_sequencer : control FSM sequencing the convolution PE datapath
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_sequencer #(
  parameter int FILTER_SIZE_REG_SIZE = pe_seq_pkg::FILTER_SIZE_REG_SIZE,
  parameter int ROW_CNT_W            = pe_seq_pkg::ROW_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic [ROW_CNT_W-1:0]            total_rows,
  input  logic                            psum_ready,
  input  logic                            av_data,
  input  logic                            av_filter,
  input  logic                            co_filter,
  input  logic                            end_of_row,
  input  logic                            end_of_filter,
  output logic                            ld_stride,
  output logic                            ld_fileSize,
  output logic                            put_data,
  output logic                            put_filter,
  output logic                            clear_sum,
  output logic                            store_buffer,
  output logic                            next_filter,
  output logic                            next_row,
  output logic                            busy,
  output logic                            done,
  output logic [ROW_CNT_W-1:0]            row_idx,
  output logic                            err
);

  import pe_seq_pkg::*;

  pe_seq_state_t        state_q;
  pe_seq_state_t        state_d;
  logic [ROW_CNT_W-1:0] rows_q;
  logic [ROW_CNT_W-1:0] last_row;
  logic                 is_config;
  logic                 issue;
  logic                 window_end;
  logic                 row_step;

  assign is_config = (state_q == CONFIG);
  assign issue     = (state_q == MAC) && av_data && av_filter;
  assign last_row  = (rows_q == '0) ? '0 : rows_q - ROW_CNT_W'(1);
  assign row_step  = (state_q == NXT_ROW) && (row_idx != last_row);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      if (is_config) begin
        rows_q <= total_rows;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_stride    = 1'b0;
    ld_fileSize  = 1'b0;
    put_data     = 1'b0;
    put_filter   = 1'b0;
    clear_sum    = 1'b0;
    store_buffer = 1'b0;
    next_filter  = 1'b0;
    next_row     = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CONFIG;
      end
      CONFIG: begin
        ld_stride   = 1'b1;
        ld_fileSize = 1'b1;
        clear_sum   = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (av_data && av_filter) state_d = MAC;
      end
      MAC: begin
        put_data   = issue;
        put_filter = issue;
        if (window_end) state_d = STORE;
      end
      STORE: begin
        store_buffer = psum_ready;
        clear_sum    = psum_ready;
        if (psum_ready) begin
          if (!end_of_row)         state_d = WAIT;
          else if (!end_of_filter) state_d = NXT_FILT;
          else                     state_d = NXT_ROW;
        end
      end
      NXT_FILT: begin
        next_filter = 1'b1;
        state_d     = WAIT;
      end
      NXT_ROW: begin
        next_row = 1'b1;
        state_d  = row_step ? WAIT : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pe_window_counter #(
    .FILTER_SIZE_REG_SIZE(FILTER_SIZE_REG_SIZE)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .load       (is_config),
    .filter_size(filter_size),
    .issue      (issue),
    .co_filter  (co_filter),
    .window_end (window_end),
    .err        (err)
  );

  Counter #(
    .WIDTH(ROW_CNT_W)
  ) u_rows (
    .clk  (clk),
    .rst  (rst),
    .clr  (is_config),
    .en   (row_step),
    .count(row_idx)
  );

endmodule

`default_nettype wire

// File: tb/tb_pe_sequencer.sv
//------------------------------------------------------------------------------
// tb_pe_sequencer : self-checking bench for pe_sequencer
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_sequencer;

  localparam int FW = 8;
  localparam int RW = 8;

  logic          clk, rst, start;
  logic [FW-1:0] filter_size;
  logic [RW-1:0] total_rows;
  logic          psum_ready, av_data, av_filter, co_filter, end_of_row, end_of_filter;
  logic          ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer;
  logic          next_filter, next_row, busy, done, err;
  logic [RW-1:0] row_idx;

  pe_sequencer #(.FILTER_SIZE_REG_SIZE(FW), .ROW_CNT_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
    .total_rows(total_rows), .psum_ready(psum_ready), .av_data(av_data),
    .av_filter(av_filter), .co_filter(co_filter), .end_of_row(end_of_row),
    .end_of_filter(end_of_filter), .ld_stride(ld_stride), .ld_fileSize(ld_fileSize),
    .put_data(put_data), .put_filter(put_filter), .clear_sum(clear_sum),
    .store_buffer(store_buffer), .next_filter(next_filter), .next_row(next_row),
    .busy(busy), .done(done), .row_idx(row_idx), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {ld_stride, ld_fileSize, put_data, put_filter, clear_sum,
                          store_buffer, next_filter, next_row, busy, done, err}, 0);
    chk({name, "_row_idx"}, row_idx, 0);
  endtask

  // Whole-job scenario: the bench plays dp, and the expected event stream is
  // derived from loop nesting rows > filters > windows.
  task automatic run_job(input int fs, input int rows, input int nf, input int nw,
                         input int co_pos, input bit stalls,
                         output int n_put, output int n_store, output int n_nf,
                         output int n_nr, output bit err_o);
    int  exp_q[$];
    int  obs_q[$];
    int  fse, re, len, wp, wi, fi, since, ld_n, n;
    bit  seen_done;
    fse = (fs == 0) ? 1 : fs;
    re  = (rows == 0) ? 1 : rows;
    len = (co_pos < fse) ? co_pos : fse;
    for (int r = 0; r < re; r++)
      for (int f = 0; f < nf; f++)
        for (int w = 0; w < nw; w++) begin
          exp_q.push_back(100 + len);
          if (w == nw - 1) exp_q.push_back((f < nf - 1) ? 1 : 200 + r);
        end
    exp_q.push_back(3);
    n_put = 0; n_store = 0; n_nf = 0; n_nr = 0; err_o = 1'b0;
    wp = 0; wi = 0; fi = 0; since = 0; ld_n = 0; seen_done = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; filter_size = FW'(fs); total_rows = RW'(rows);
    av_data = 1'b1; av_filter = 1'b1; psum_ready = 1'b1;
    co_filter = (co_pos == 1); end_of_row = (nw == 1); end_of_filter = (nw == 1) && (nf == 1);
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      chk("put_pair", put_data, put_filter);
      chk("clear_sum_decode", clear_sum, store_buffer | ld_stride);
      chk("ld_pair", ld_stride, ld_fileSize);
      chk("ctrl_no_overlap", (ld_stride | next_filter | next_row) & put_data, 0);
      if (put_data) chk("put_needs_operands", av_data & av_filter, 1);
      if (store_buffer) chk("store_needs_ready", psum_ready, 1);
      if (ld_stride) ld_n++;
      if (put_data) begin wp++; since++; n_put++; end
      if (store_buffer) begin
        obs_q.push_back(100 + since);
        since = 0; wp = 0; n_store++;
        if (wi == nw - 1) begin
          wi = 0;
          fi = (fi == nf - 1) ? 0 : fi + 1;
        end else begin
          wi++;
        end
      end
      if (next_filter) begin obs_q.push_back(1); n_nf++; end
      if (next_row) begin obs_q.push_back(200 + int'(row_idx)); n_nr++; end
      if (done) begin
        obs_q.push_back(3);
        seen_done = 1'b1;
        err_o = err;
        chk("final_row_idx", row_idx, re - 1);
      end
      @(posedge clk); #1;
      start         = 1'b0;
      av_data       = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      av_filter     = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      psum_ready    = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      co_filter     = (wp + 1 == co_pos);
      end_of_row    = (wi == nw - 1);
      end_of_filter = (wi == nw - 1) && (fi == nf - 1);
    end
    if (!seen_done) chk("job_timeout", 0, 1);
    chk("event_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("event_%0d", i), obs_q[i], exp_q[i]);
    chk("ld_once", ld_n, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  typedef struct {
    int fs; int rows; int nf; int nw; int co_pos; bit stalls;
    int e_put; int e_store; int e_nf; int e_nr; bit e_err;
  } job_t;

  typedef struct {
    int fs; int co_pos;
    logic [15:0] avf_low, ps_low;
    logic [15:0] ld, put, store, clr, nr, dn, bsy, er;
  } seq_t;

  // Cycle-exact single-window job; cycle 0 is the cycle start is presented.
  task automatic seq_run(input seq_t s, input string tag);
    int puts;
    puts = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      start = (c == 0); filter_size = FW'(s.fs); total_rows = RW'(1);
      av_data = 1'b1; av_filter = !s.avf_low[c]; psum_ready = !s.ps_low[c];
      co_filter = (puts == s.co_pos - 1); end_of_row = 1'b1; end_of_filter = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_ld_c%0d", tag, c), ld_stride & ld_fileSize, s.ld[c]);
      chk($sformatf("%s_put_c%0d", tag, c), put_data & put_filter, s.put[c]);
      chk($sformatf("%s_store_c%0d", tag, c), store_buffer, s.store[c]);
      chk($sformatf("%s_clr_c%0d", tag, c), clear_sum, s.clr[c]);
      chk($sformatf("%s_nrow_c%0d", tag, c), next_row, s.nr[c]);
      chk($sformatf("%s_nfilt_c%0d", tag, c), next_filter, 0);
      chk($sformatf("%s_done_c%0d", tag, c), done, s.dn[c]);
      chk($sformatf("%s_busy_c%0d", tag, c), busy, s.bsy[c]);
      chk($sformatf("%s_err_c%0d", tag, c), err, s.er[c]);
      if (put_data) puts++;
    end
  endtask

  initial begin
    job_t jobs[7];
    seq_t seqs[5];
    int   np, ns, nnf, nnr;
    bit   e;

    jobs[0] = '{3, 1, 1, 1, 3, 1'b0,  3, 1, 0, 1, 1'b0};
    jobs[1] = '{3, 2, 2, 1, 3, 1'b0, 12, 4, 2, 2, 1'b0};
    jobs[2] = '{3, 1, 1, 2, 2, 1'b0,  4, 2, 0, 1, 1'b1};
    jobs[3] = '{0, 0, 1, 3, 1, 1'b0,  3, 3, 0, 1, 1'b0};
    jobs[4] = '{4, 3, 1, 2, 4, 1'b1, 24, 6, 0, 3, 1'b0};
    jobs[5] = '{2, 1, 3, 1, 5, 1'b1,  6, 3, 2, 1, 1'b1};
    jobs[6] = '{1, 2, 1, 1, 1, 1'b0,  2, 2, 0, 2, 1'b0};

    //            fs co avf_low  ps_low   ld       put      store    clr      nr       done     busy     err
    seqs[0] = '{3, 3, 16'h0000, 16'h0000, 16'h0002, 16'h0038, 16'h0040, 16'h0042, 16'h0080, 16'h0100, 16'h01FE, 16'h0000};
    seqs[1] = '{3, 3, 16'h0030, 16'h0000, 16'h0002, 16'h00C8, 16'h0100, 16'h0102, 16'h0200, 16'h0400, 16'h07FE, 16'h0000};
    seqs[2] = '{2, 2, 16'h0000, 16'h01E0, 16'h0002, 16'h0018, 16'h0200, 16'h0202, 16'h0400, 16'h0800, 16'h0FFE, 16'h0000};
    seqs[3] = '{3, 2, 16'h0000, 16'h0000, 16'h0002, 16'h0018, 16'h0020, 16'h0022, 16'h0040, 16'h0080, 16'h00FE, 16'hFFE0};
    seqs[4] = '{3, 3, 16'h0000, 16'h0000, 16'h0002, 16'h0038, 16'h0040, 16'h0042, 16'h0080, 16'h0100, 16'h01FE, 16'h0003};

    rst = 1'b1; start = 1'b0; filter_size = '0; total_rows = '0;
    psum_ready = 1'b0; av_data = 1'b0; av_filter = 1'b0; co_filter = 1'b0;
    end_of_row = 1'b0; end_of_filter = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) seq_run(seqs[i], $sformatf("seq%0d", i));

    for (int i = 0; i < 7; i++) begin
      run_job(jobs[i].fs, jobs[i].rows, jobs[i].nf, jobs[i].nw, jobs[i].co_pos,
              jobs[i].stalls, np, ns, nnf, nnr, e);
      chk($sformatf("job%0d_puts", i), np, jobs[i].e_put);
      chk($sformatf("job%0d_stores", i), ns, jobs[i].e_store);
      chk($sformatf("job%0d_next_filter", i), nnf, jobs[i].e_nf);
      chk($sformatf("job%0d_next_row", i), nnr, jobs[i].e_nr);
      chk($sformatf("job%0d_err", i), e, jobs[i].e_err);
    end

    // Async reset in the middle of MAC.
    @(posedge clk); #1;
    start = 1'b1; filter_size = FW'(3); total_rows = RW'(2);
    av_data = 1'b1; av_filter = 1'b1; psum_ready = 1'b1; co_filter = 1'b0;
    end_of_row = 1'b1; end_of_filter = 1'b1;
    repeat (3) begin
      @(posedge clk); #1 start = 1'b0;
    end
    @(negedge clk);
    chk("pre_reset_in_mac", put_data, 1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset_done_c%0d", c), done, 0);
      chk($sformatf("post_reset_busy_c%0d", c), busy, 0);
    end
    run_job(3, 1, 1, 1, 3, 1'b0, np, ns, nnf, nnr, e);
    chk("after_reset_puts", np, 3);
    chk("after_reset_err", e, 0);

    for (int k = 0; k < 25; k++) begin
      int fs, fse, rows, nf, nw, co_pos;
      fs     = $urandom_range(0, 5);
      fse    = (fs == 0) ? 1 : fs;
      rows   = $urandom_range(0, 3);
      nf     = $urandom_range(1, 3);
      nw     = $urandom_range(1, 3);
      co_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fse + 1) : fse;
      run_job(fs, rows, nf, nw, co_pos, 1'b1, np, ns, nnf, nnr, e);
      chk($sformatf("rand%0d_err", k), e, co_pos != fse);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
